// File: rtl/ws2812_defs_pkg.sv
// -----------------------------------------------------------------------------
// ws2812_defs_pkg
// Shared WS2812b definitions used by both the receive decoder and the
// transmitter: timing defaults (in clocks at 100 MHz), word width, counter
// widths and the decoder state type.
// -----------------------------------------------------------------------------
package ws2812_defs_pkg;

  localparam int unsigned T_MIN_HIGH_DEF = 20;
  localparam int unsigned T_THRESH_DEF   = 60;
  localparam int unsigned T_MAX_HIGH_DEF = 100;
  localparam int unsigned T_RESET_DEF    = 5000;

  localparam int unsigned WORD_W    = 24;
  localparam int unsigned CNT_W     = 13;
  localparam int unsigned BIT_CNT_W = $clog2(WORD_W);
  localparam int unsigned PIX_CNT_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HIGH,
    ST_LOW,
    ST_DISCARD
  } rx_state_t;

  // Converts a timing constant to counter width, clamping at the counter max.
  function automatic logic [CNT_W-1:0] to_cnt(input int unsigned v);
    if (v > ((1 << CNT_W) - 1)) begin
      return '1;
    end
    return CNT_W'(v);
  endfunction

endpackage

// File: rtl/ws2812_sync_edge.sv
// -----------------------------------------------------------------------------
// ws2812_sync_edge
// Two-flop synchronizer for the asynchronous WS2812b line followed by a
// registered edge detector.
//   i_clk   : clock
//   i_rst_n : asynchronous active-low reset
//   i_din   : asynchronous serial line
//   rise    : one-cycle strobe, synchronized line went 0 -> 1
//   fall    : one-cycle strobe, synchronized line went 1 -> 0
//   level   : synchronized line level, aligned with rise/fall
// -----------------------------------------------------------------------------
module ws2812_sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_din,
  output logic rise,
  output logic fall,
  output logic level
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      meta_q <= i_din;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise   <= sync_q & ~prev_q;
      fall   <= ~sync_q & prev_q;
    end
  end

  // prev_q changes on the same edge that registers rise/fall
  assign level = prev_q;

endmodule

// File: rtl/ws2812_rx_decoder.sv
// -----------------------------------------------------------------------------
// ws2812_rx_decoder
// Decodes a WS2812b NZR serial stream into 24-bit GRB words by measuring the
// width of each high pulse.
//   i_clk         : clock, 100 MHz nominal
//   i_rst_n       : asynchronous active-low reset
//   i_din         : asynchronous serial line
//   o_pixel       : last complete word, bit 23 = first bit received
//   o_pixel_valid : one-cycle strobe, o_pixel updated in the same cycle
//   o_frame_end   : one-cycle strobe when the low time reaches T_RESET
//   o_bit_err     : one-cycle strobe on an illegal pulse or partial word at
//                   frame end
//   o_pixel_cnt   : words since last frame end, saturating
//   o_busy        : high from the first rising edge until frame end
// -----------------------------------------------------------------------------
module ws2812_rx_decoder
  import ws2812_defs_pkg::*;
#(
  parameter int unsigned T_MIN_HIGH = T_MIN_HIGH_DEF,
  parameter int unsigned T_THRESH   = T_THRESH_DEF,
  parameter int unsigned T_MAX_HIGH = T_MAX_HIGH_DEF,
  parameter int unsigned T_RESET    = T_RESET_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_din,
  output logic [WORD_W-1:0]    o_pixel,
  output logic                 o_pixel_valid,
  output logic                 o_frame_end,
  output logic                 o_bit_err,
  output logic [PIX_CNT_W-1:0] o_pixel_cnt,
  output logic                 o_busy
);

  localparam logic [CNT_W-1:0]     MIN_C    = to_cnt(T_MIN_HIGH);
  localparam logic [CNT_W-1:0]     THRESH_C = to_cnt(T_THRESH);
  localparam logic [CNT_W-1:0]     MAX_C    = to_cnt(T_MAX_HIGH);
  localparam logic [CNT_W-1:0]     LONG_C   = to_cnt(T_MAX_HIGH + 1);
  localparam logic [CNT_W-1:0]     RESET_C  = to_cnt(T_RESET);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(WORD_W - 1);

  logic rise;
  logic fall;
  logic level;

  ws2812_sync_edge u_sync_edge (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_din   (i_din),
    .rise    (rise),
    .fall    (fall),
    .level   (level)
  );

  rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q;
  logic [WORD_W-1:0]    shift_q, shift_d;
  logic [BIT_CNT_W-1:0] bitcnt_q, bitcnt_d;
  logic [WORD_W-1:0]    pixel_d;
  logic [PIX_CNT_W-1:0] pixcnt_d;
  logic                 busy_d;
  logic                 valid_d;
  logic                 frame_end_d;
  logic                 err_d;
  logic                 bit_val;
  logic [WORD_W-1:0]    word_next;

  // Width counter. It reloads with 1 rather than 0 on an edge so that, when
  // the next edge is seen, cnt_q equals the number of clocks the line spent
  // at the previous level; the thresholds then compare directly.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else if (rise || fall) begin
      cnt_q <= CNT_W'(1);
    end else if (cnt_q < RESET_C) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= ST_IDLE;
      shift_q       <= '0;
      bitcnt_q      <= '0;
      o_pixel       <= '0;
      o_pixel_valid <= 1'b0;
      o_frame_end   <= 1'b0;
      o_bit_err     <= 1'b0;
      o_pixel_cnt   <= '0;
      o_busy        <= 1'b0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      bitcnt_q      <= bitcnt_d;
      o_pixel       <= pixel_d;
      o_pixel_valid <= valid_d;
      o_frame_end   <= frame_end_d;
      o_bit_err     <= err_d;
      o_pixel_cnt   <= pixcnt_d;
      o_busy        <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bitcnt_d    = bitcnt_q;
    pixel_d     = o_pixel;
    pixcnt_d    = o_pixel_cnt;
    busy_d      = o_busy;
    valid_d     = 1'b0;
    frame_end_d = 1'b0;
    err_d       = 1'b0;
    bit_val     = (cnt_q >= THRESH_C);
    word_next   = {shift_q[WORD_W-2:0], bit_val};

    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_HIGH;
          busy_d  = 1'b1;
        end
      end

      ST_HIGH: begin
        if (fall) begin
          state_d = ST_LOW;
          // An illegal pulse never produces a bit, so error always wins
          // over pixel_valid.
          if ((cnt_q < MIN_C) || (cnt_q > MAX_C)) begin
            err_d    = 1'b1;
            shift_d  = '0;
            bitcnt_d = '0;
          end else if (bitcnt_q == LAST_BIT) begin
            pixel_d  = word_next;
            valid_d  = 1'b1;
            shift_d  = '0;
            bitcnt_d = '0;
            if (o_pixel_cnt != '1) begin
              pixcnt_d = o_pixel_cnt + PIX_CNT_W'(1);
            end
          end else begin
            shift_d  = word_next;
            bitcnt_d = bitcnt_q + BIT_CNT_W'(1);
          end
        end else if (cnt_q == LONG_C) begin
          state_d  = ST_DISCARD;
          err_d    = 1'b1;
          shift_d  = '0;
          bitcnt_d = '0;
        end
      end

      ST_DISCARD: begin
        if (fall) begin
          state_d = ST_LOW;
        end
      end

      ST_LOW: begin
        // A rising edge landing on the frame-end cycle starts the next bit.
        if (rise) begin
          state_d = ST_HIGH;
        end else if ((cnt_q == RESET_C) && !level) begin
          state_d     = ST_IDLE;
          frame_end_d = 1'b1;
          busy_d      = 1'b0;
          pixcnt_d    = '0;
          shift_d     = '0;
          bitcnt_d    = '0;
          err_d       = (bitcnt_q != '0);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule
